// File: rtl/mem_resp.sv
// Bridges execution-unit memory/I/O requests onto a 16-bit Wishbone bus, splitting
// misaligned word accesses into two byte-lane transfers and assembling read data.
module mem_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [19:0] cpu_addr,
    input  logic [15:0] cpu_wdat,
    input  logic        cpu_we,
    input  logic        cpu_m_io,
    input  logic        cpu_byteop,
    output logic [15:0] cpu_rdat,
    output logic        cpu_block,
    output logic [18:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    output logic [1:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_tga_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [19:0] addr_r, addr_nxt_s;
    logic [15:0] wdat_r, wdat_nxt_s;
    logic        we_r, we_nxt_s;
    logic        m_io_r, m_io_nxt_s;
    logic        byteop_r, byteop_nxt_s;
    logic [7:0]  lo_byte_r, lo_byte_nxt_s;
    logic [18:0] adr_nxt_s;
    logic [15:0] dat_nxt_s;
    logic [1:0]  sel_nxt_s;
    logic        wb_we_nxt_s, tga_nxt_s, cyc_nxt_s, stb_nxt_s;
    logic [15:0] rdat_nxt_s;

    // First-transfer lane enables: odd byte and split word both start on the high lane.
    function automatic logic [1:0] lo_sel(input logic a0, input logic byteop);
        logic [1:0] sel;
        if (a0) begin
            sel = 2'b10;
        end else if (byteop) begin
            sel = 2'b01;
        end else begin
            sel = 2'b11;
        end
        return sel;
    endfunction

    function automatic logic [15:0] lo_dat(input logic a0, input logic byteop, input logic [15:0] wdat);
        logic [15:0] dat;
        if (byteop) begin
            dat = {wdat[7:0], wdat[7:0]};
        end else if (a0) begin
            dat = {wdat[7:0], 8'h00};
        end else begin
            dat = wdat;
        end
        return dat;
    endfunction

    function automatic logic [15:0] single_rdat(input logic a0, input logic byteop, input logic [15:0] d);
        logic [15:0] r;
        if (!byteop) begin
            r = d;
        end else if (a0) begin
            r = {8'h00, d[15:8]};
        end else begin
            r = {8'h00, d[7:0]};
        end
        return r;
    endfunction

    assign cpu_block = cpu_req & (state_r != ST_DONE);

    // Next-state and next-value computation for every registered output.
    always_comb begin
        state_nxt_s   = state_r;
        addr_nxt_s    = addr_r;
        wdat_nxt_s    = wdat_r;
        we_nxt_s      = we_r;
        m_io_nxt_s    = m_io_r;
        byteop_nxt_s  = byteop_r;
        lo_byte_nxt_s = lo_byte_r;
        adr_nxt_s     = wb_adr_o;
        dat_nxt_s     = wb_dat_o;
        sel_nxt_s     = wb_sel_o;
        wb_we_nxt_s   = wb_we_o;
        tga_nxt_s     = wb_tga_o;
        cyc_nxt_s     = wb_cyc_o;
        stb_nxt_s     = wb_stb_o;
        rdat_nxt_s    = cpu_rdat;
        case (state_r)
            ST_IDLE: begin
                cyc_nxt_s = 1'b0;
                stb_nxt_s = 1'b0;
                if (cpu_req) begin
                    state_nxt_s  = ST_LO;
                    addr_nxt_s   = cpu_addr;
                    wdat_nxt_s   = cpu_wdat;
                    we_nxt_s     = cpu_we;
                    m_io_nxt_s   = cpu_m_io;
                    byteop_nxt_s = cpu_byteop;
                    adr_nxt_s    = cpu_addr[19:1];
                    sel_nxt_s    = lo_sel(cpu_addr[0], cpu_byteop);
                    dat_nxt_s    = lo_dat(cpu_addr[0], cpu_byteop, cpu_wdat);
                    wb_we_nxt_s  = cpu_we;
                    tga_nxt_s    = cpu_m_io;
                    cyc_nxt_s    = 1'b1;
                    stb_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LO: begin
                if (wb_ack_i && !byteop_r && addr_r[0]) begin
                    // Split word: the high lane of this word is the low byte of the result.
                    state_nxt_s   = ST_HI;
                    lo_byte_nxt_s = wb_dat_i[15:8];
                    adr_nxt_s     = addr_r[19:1] + 19'd1;
                    sel_nxt_s     = 2'b01;
                    dat_nxt_s     = {8'h00, wdat_r[15:8]};
                end else if (wb_ack_i) begin
                    state_nxt_s = ST_DONE;
                    cyc_nxt_s   = 1'b0;
                    stb_nxt_s   = 1'b0;
                    if (!we_r) begin
                        rdat_nxt_s = single_rdat(addr_r[0], byteop_r, wb_dat_i);
                    end else begin
                        rdat_nxt_s = cpu_rdat;
                    end
                end else begin
                    state_nxt_s = ST_LO;
                end
            end
            ST_HI: begin
                if (wb_ack_i) begin
                    state_nxt_s = ST_DONE;
                    cyc_nxt_s   = 1'b0;
                    stb_nxt_s   = 1'b0;
                    if (!we_r) begin
                        rdat_nxt_s = {wb_dat_i[7:0], lo_byte_r};
                    end else begin
                        rdat_nxt_s = cpu_rdat;
                    end
                end else begin
                    state_nxt_s = ST_HI;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cyc_nxt_s   = 1'b0;
                stb_nxt_s   = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cyc_nxt_s   = 1'b0;
                stb_nxt_s   = 1'b0;
            end
        endcase
    end

    // State, latched request qualifiers and all bus/CPU output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            addr_r    <= 20'h00000;
            wdat_r    <= 16'h0000;
            we_r      <= 1'b0;
            m_io_r    <= 1'b0;
            byteop_r  <= 1'b0;
            lo_byte_r <= 8'h00;
            wb_adr_o  <= 19'h00000;
            wb_dat_o  <= 16'h0000;
            wb_sel_o  <= 2'b00;
            wb_we_o   <= 1'b0;
            wb_tga_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            cpu_rdat  <= 16'h0000;
        end else begin
            state_r   <= state_nxt_s;
            addr_r    <= addr_nxt_s;
            wdat_r    <= wdat_nxt_s;
            we_r      <= we_nxt_s;
            m_io_r    <= m_io_nxt_s;
            byteop_r  <= byteop_nxt_s;
            lo_byte_r <= lo_byte_nxt_s;
            wb_adr_o  <= adr_nxt_s;
            wb_dat_o  <= dat_nxt_s;
            wb_sel_o  <= sel_nxt_s;
            wb_we_o   <= wb_we_nxt_s;
            wb_tga_o  <= tga_nxt_s;
            wb_cyc_o  <= cyc_nxt_s;
            wb_stb_o  <= stb_nxt_s;
            cpu_rdat  <= rdat_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: the bench plays the Wishbone slave, checks every bus
// phase against its own lane model and compares read results popped from a queue.
module tb_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [19:0] cpu_addr;
    logic [15:0] cpu_wdat;
    logic        cpu_we, cpu_m_io, cpu_byteop;
    logic [15:0] cpu_rdat;
    logic        cpu_block;
    logic [18:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_o;
    logic        wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_rdat;

    mem_resp dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdat(cpu_wdat),
        .cpu_we(cpu_we), .cpu_m_io(cpu_m_io), .cpu_byteop(cpu_byteop),
        .cpu_rdat(cpu_rdat), .cpu_block(cpu_block),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete CPU access, entered and left at a falling edge.
    task automatic access(input logic [19:0] addr, input logic [15:0] wdat, input logic we,
                          input logic mio, input logic bop, input logic [15:0] lo_d,
                          input logic [15:0] hi_d, input int dly);
        logic        split;
        logic [18:0] adr_lo, adr_hi;
        logic [1:0]  sel_lo;
        logic [15:0] dat_lo, exp_r, got;
        split  = !bop && addr[0];
        adr_lo = addr[19:1];
        adr_hi = adr_lo + 19'd1;
        if (bop) sel_lo = addr[0] ? 2'b10 : 2'b01;
        else     sel_lo = addr[0] ? 2'b10 : 2'b11;
        if (bop)        dat_lo = {wdat[7:0], wdat[7:0]};
        else if (split) dat_lo = {wdat[7:0], 8'h00};
        else            dat_lo = wdat;
        if (we)         exp_r = model_rdat;
        else if (bop)   exp_r = addr[0] ? {8'h00, lo_d[15:8]} : {8'h00, lo_d[7:0]};
        else if (split) exp_r = {hi_d[7:0], lo_d[15:8]};
        else            exp_r = lo_d;
        model_rdat = exp_r;
        exp_q.push_back(exp_r);

        cpu_req = 1'b1; cpu_addr = addr; cpu_wdat = wdat;
        cpu_we = we; cpu_m_io = mio; cpu_byteop = bop;
        #1;
        check_val("block_idle", {31'd0, cpu_block}, 32'd1);
        check_val("cyc_idle", {31'd0, wb_cyc_o}, 32'd0);
        @(negedge clk);
        check_val("cyc_lo", {31'd0, wb_cyc_o}, 32'd1);
        check_val("stb_lo", {31'd0, wb_stb_o}, 32'd1);
        check_val("adr_lo", {13'd0, wb_adr_o}, {13'd0, adr_lo});
        check_val("sel_lo", {30'd0, wb_sel_o}, {30'd0, sel_lo});
        if (we) check_val("dat_lo", {16'd0, wb_dat_o}, {16'd0, dat_lo});
        check_val("we_lo", {31'd0, wb_we_o}, {31'd0, we});
        check_val("tga_lo", {31'd0, wb_tga_o}, {31'd0, mio});
        check_val("block_lo", {31'd0, cpu_block}, 32'd1);
        // Qualifiers wander mid-access; the DUT must keep using the latched copy.
        cpu_addr = 20'($urandom); cpu_wdat = 16'($urandom);
        cpu_we = ~we; cpu_m_io = ~mio; cpu_byteop = ~bop;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check_val("stb_wait", {31'd0, wb_stb_o}, 32'd1);
            check_val("block_wait", {31'd0, cpu_block}, 32'd1);
        end
        wb_ack_i = 1'b1; wb_dat_i = lo_d;
        @(negedge clk);
        wb_ack_i = 1'b0; wb_dat_i = 16'($urandom);
        if (split) begin
            check_val("cyc_hi", {31'd0, wb_cyc_o}, 32'd1);
            check_val("stb_hi", {31'd0, wb_stb_o}, 32'd1);
            check_val("adr_hi", {13'd0, wb_adr_o}, {13'd0, adr_hi});
            check_val("sel_hi", {30'd0, wb_sel_o}, 32'd1);
            if (we) check_val("dat_hi", {16'd0, wb_dat_o}, {24'd0, wdat[15:8]});
            wb_ack_i = 1'b1; wb_dat_i = hi_d;
            @(negedge clk);
            wb_ack_i = 1'b0; wb_dat_i = 16'($urandom);
        end
        check_val("cyc_done", {31'd0, wb_cyc_o}, 32'd0);
        check_val("stb_done", {31'd0, wb_stb_o}, 32'd0);
        check_val("block_done", {31'd0, cpu_block}, 32'd0);
        got = exp_q.pop_front();
        check_val("rdat", {16'd0, cpu_rdat}, {16'd0, got});
        cpu_req = 1'b0;
        @(negedge clk);
        check_val("cyc_after", {31'd0, wb_cyc_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = 20'h00000; cpu_wdat = 16'h0000;
        cpu_we = 1'b0; cpu_m_io = 1'b0; cpu_byteop = 1'b0;
        wb_dat_i = 16'h0000; wb_ack_i = 1'b0; model_rdat = 16'h0000;
        repeat (2) @(negedge clk);
        check_val("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check_val("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check_val("rst_sel", {30'd0, wb_sel_o}, 32'd0);
        check_val("rst_adr", {13'd0, wb_adr_o}, 32'd0);
        check_val("rst_dat", {16'd0, wb_dat_o}, 32'd0);
        check_val("rst_we_tga", {30'd0, wb_we_o, wb_tga_o}, 32'd0);
        check_val("rst_rdat", {16'd0, cpu_rdat}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        access(20'h01234, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 0);
        access(20'h00101, 16'h0055, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 0);
        access(20'h00003, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hAA11, 16'h22BB, 0);
        access(20'hFFFFF, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1);
        access(20'h00041, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h9C7E, 16'h0000, 3);
        access(20'h00200, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1357, 16'h0000, 0);
        access(20'h00410, 16'hC0DE, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 2);

        // Stray ack while idle must not start or complete anything.
        wb_ack_i = 1'b1; wb_dat_i = 16'hDEAD;
        @(negedge clk);
        wb_ack_i = 1'b0;
        check_val("stray_ack_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check_val("stray_ack_rdat", {16'd0, cpu_rdat}, {16'd0, model_rdat});

        for (int k = 0; k < 8; k++) begin
            access(20'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset while the second half of a split read is outstanding.
        cpu_req = 1'b1; cpu_addr = 20'h00005; cpu_we = 1'b0; cpu_m_io = 1'b0; cpu_byteop = 1'b0;
        @(negedge clk);
        wb_ack_i = 1'b1; wb_dat_i = 16'h7700;
        @(negedge clk);
        wb_ack_i = 1'b0;
        check_val("pre_rst_cyc_hi", {31'd0, wb_cyc_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check_val("async_rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check_val("async_rst_rdat", {16'd0, cpu_rdat}, 32'd0);
        check_val("async_rst_adr", {13'd0, wb_adr_o}, 32'd0);
        model_rdat = 16'h0000;
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0;
        wb_ack_i = 1'b1; wb_dat_i = 16'h0066;
        @(negedge clk);
        wb_ack_i = 1'b0;
        check_val("post_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check_val("post_rst_rdat", {16'd0, cpu_rdat}, 32'd0);
        access(20'h01234, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 0);

        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 The block SHALL have no parameters; the bus width is fixed at 16 bits and the address width at 20 bits.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_req  in  1  access request from the execution unit; held with stable qualifiers while cpu_block=1.
REQ-005 cpu_addr  in  20  byte address.
REQ-006 cpu_wdat  in  16  write data; bits [7:0] are the byte at cpu_addr.
REQ-007 cpu_we  in  1  1=write, 0=read.
REQ-008 cpu_m_io  in  1  1=I/O space, 0=memory space.
REQ-009 cpu_byteop  in  1  1=byte access, 0=word access.
REQ-010 cpu_rdat  out  16  read data (memout), registered.
REQ-011 cpu_block  out  1  stall to the execution unit.
REQ-012 wb_adr_o  out  19  word address, bits [19:1].
REQ-013 wb_dat_o  out  16  write data, lane-steered.
REQ-014 wb_sel_o  out  2  byte lane enables; bit0=low lane (even byte), bit1=high lane.
REQ-015 wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o  out  1 each  write, I/O tag (=m_io), cycle, strobe.
REQ-016 wb_dat_i  in  16  read data.
REQ-017 wb_ack_i  in  1  single-cycle acknowledge.

Function
REQ-018 The FSM SHALL have the states IDLE, LO, HI and DONE; all wb_* outputs and cpu_rdat SHALL be registered.
REQ-019 IDLE: when cpu_req=1, the block SHALL latch addr/wdat/we/m_io/byteop and go to LO, asserting cyc/stb from the next cycle.
REQ-020 A request is split when cpu_byteop=0 and cpu_addr[0]=1; all other requests are single.
REQ-021 LO: wb_adr_o SHALL be addr[19:1].
REQ-022 LO sel: byte even=01; byte odd=10; aligned word=11; split=10.
REQ-023 LO dat_o: byte={wdat[7:0],wdat[7:0]}; aligned word=wdat; split={wdat[7:0],8'h00}.
REQ-024 On wb_ack_i in LO, the block SHALL go to DONE if the request is single, otherwise to HI.
REQ-025 On the LO->HI transition, cyc/stb SHALL stay high with no idle gap.
REQ-026 HI: wb_adr_o SHALL be addr[19:1]+1 (modulo 2^19, so 0xFFFFF wraps to word 0); sel=01; dat_o={8'h00,wdat[15:8]}.
REQ-027 On wb_ack_i in HI, the block SHALL go to DONE.
REQ-028 Leaving LO/HI on ack, cyc and stb SHALL drop in the same edge; in DONE and IDLE, cyc=stb=0.
REQ-029 Read capture: byte={8'h00, selected lane}; aligned word=wb_dat_i; split={HI lane[7:0], LO lane[15:8]}; cpu_rdat SHALL be valid in DONE and hold until the next capture.
REQ-030 Writes SHALL leave cpu_rdat unchanged.
REQ-031 cpu_block SHALL equal cpu_req AND (state != DONE), combinationally.
REQ-032 DONE SHALL always go to IDLE; a cpu_req seen in that IDLE cycle is a new access.
REQ-033 wb_ack_i outside LO/HI SHALL be ignored.
REQ-034 Latched qualifiers SHALL be used for the whole access; cpu_* changes mid-access SHALL be ignored.
REQ-035 There SHALL be no timeout; the block waits indefinitely for ack.

Reset
REQ-036 rst=1 SHALL force IDLE immediately, with cyc=stb=we=tga=0, sel=00, adr=0, dat_o=0 and cpu_rdat=0.
REQ-037 Reset mid-access SHALL abandon the bus cycle with no completion, and the first edge after release SHALL be IDLE.

Verification
REQ-038 Aligned word read, addr=0x01234, ack in first bus cycle, dat_i=0xBEEF -> adr=0x091A, sel=11, block high 2 cycles then low, rdat=0xBEEF.
REQ-039 Byte write, addr=0x00101, wdat=0x0055 -> one bus cycle with sel=10, dat_o=0x5555, we=1; rdat unchanged.
REQ-040 Split read, addr=0x00003, LO dat_i=0xAA11, HI dat_i=0x22BB -> adr 0x0001 then 0x0002, sel 10 then 01, cyc continuous, rdat=0xBBAA.
REQ-041 Split write, addr=0xFFFFF, wdat=0x1234 -> adr 0x7FFFF sel=10 dat_o=0x3400, then adr 0x00000 sel=01 dat_o=0x0012.
REQ-042 I/O byte read, m_io=1, ack delayed 3 cycles -> tga=1 and stb held 4 cycles, block high until DONE, rdat upper byte=0x00.
REQ-043 rst asserted during HI -> cyc/stb drop asynchronously, FSM in IDLE, and a later ack is ignored.
